// File: rtl/expedidor_duzias.sv
// expedidor_duzias: unpacks a request of N dozens into N*DUZIA unit pulses on incrementar
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   iniciar             start request, rising-edge detected
//   duzias_in           dozens to send, sampled on the accepted start edge
//   cancelar            level, aborts after the current pulse completes
//   incrementar         unit pulse train (high HIGH_CYCLES, low LOW_CYCLES)
//   ocupado             transfer in progress (ALTO, BAIXO, FIM)
//   concluido           one-cycle pulse at the end of a transfer
//   erro                one-cycle pulse on a rejected request
//   duzias_restantes    dozens not yet fully sent, including the current one
//   unidades_restantes  units left in the current dozen
module expedidor_duzias #(
    parameter logic [6:0] MAX_DUZIAS  = 7'd10,
    parameter logic [3:0] DUZIA       = 4'd12,
    parameter logic [7:0] HIGH_CYCLES = 8'd1,
    parameter logic [7:0] LOW_CYCLES  = 8'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [6:0] duzias_in,
    input  logic       cancelar,
    output logic       incrementar,
    output logic       ocupado,
    output logic       concluido,
    output logic       erro,
    output logic [6:0] duzias_restantes,
    output logic [3:0] unidades_restantes
);
    typedef enum logic [1:0] {OCIOSO, ALTO, BAIXO, FIM} estado_t;
    estado_t estado, proximo;
    logic [7:0] fase;
    logic iniciar_prev, cancel_pend, inicio, valido, ultimo, ativo;

    assign inicio = iniciar & ~iniciar_prev;
    assign valido = duzias_in != 7'd0 && duzias_in <= MAX_DUZIAS;
    assign ativo = estado == ALTO || estado == BAIXO;
    assign incrementar = estado == ALTO;
    assign ocupado = estado != OCIOSO;
    assign concluido = estado == FIM;

    always_comb begin
        proximo = estado;
        ultimo = 1'b0;
        case (estado)
            OCIOSO: proximo = inicio && valido ? ALTO : OCIOSO;
            ALTO: begin
                ultimo = fase == HIGH_CYCLES - 8'd1;
                proximo = ultimo ? BAIXO : ALTO;
            end
            BAIXO: begin
                ultimo = fase == LOW_CYCLES - 8'd1;
                proximo = !ultimo ? BAIXO : (duzias_restantes == 7'd0 || cancel_pend) ? FIM : ALTO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    // iniciar_prev resets high so a start held through reset release is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            fase <= 8'd0;
            iniciar_prev <= 1'b1;
            cancel_pend <= 1'b0;
            erro <= 1'b0;
            duzias_restantes <= 7'd0;
            unidades_restantes <= 4'd0;
        end else begin
            estado <= proximo;
            iniciar_prev <= iniciar;
            erro <= estado == OCIOSO && inicio && !valido;
            fase <= ativo && !ultimo ? fase + 8'd1 : 8'd0;
            if (ativo && cancelar)
                cancel_pend <= 1'b1;
            if (estado == OCIOSO && inicio && valido) begin
                duzias_restantes <= duzias_in;
                unidades_restantes <= DUZIA;
                cancel_pend <= 1'b0;
            end else if (estado == ALTO && ultimo) begin
                // the unit is committed at the end of its high phase
                if (unidades_restantes == 4'd1) begin
                    duzias_restantes <= duzias_restantes - 7'd1;
                    unidades_restantes <= duzias_restantes != 7'd1 ? DUZIA : 4'd0;
                end else begin
                    unidades_restantes <= unidades_restantes - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_expedidor_duzias.sv
// tb_expedidor_duzias: directed self-checking bench for expedidor_duzias
module tb_expedidor_duzias;
    logic clk = 1'b0, reset, iniciar_a, iniciar_b, cancelar;
    logic [6:0] duzias_in;
    logic incr_a, ocup_a, concl_a, erro_a, incr_b, ocup_b, concl_b, erro_b;
    logic [6:0] dr_a, dr_b;
    logic [3:0] ur_a, ur_b;
    int errors = 0, checks = 0;
    int pa = 0, pb = 0, ca = 0, cb = 0, ea = 0, eb = 0;
    int sp, sc, se;
    logic ia_q = 1'b0, ib_q = 1'b0;

    always #5 clk = ~clk;

    expedidor_duzias u_a (
        .clk(clk), .reset(reset), .iniciar(iniciar_a), .duzias_in(duzias_in), .cancelar(cancelar),
        .incrementar(incr_a), .ocupado(ocup_a), .concluido(concl_a), .erro(erro_a),
        .duzias_restantes(dr_a), .unidades_restantes(ur_a)
    );

    expedidor_duzias #(.HIGH_CYCLES(8'd2), .LOW_CYCLES(8'd3)) u_b (
        .clk(clk), .reset(reset), .iniciar(iniciar_b), .duzias_in(duzias_in), .cancelar(cancelar),
        .incrementar(incr_b), .ocupado(ocup_b), .concluido(concl_b), .erro(erro_b),
        .duzias_restantes(dr_b), .unidades_restantes(ur_b)
    );

    // downstream view: count rising edges of incrementar and output pulses
    always @(negedge clk) begin
        if (incr_a && !ia_q) pa++;
        if (incr_b && !ib_q) pb++;
        ia_q = incr_a;
        ib_q = incr_b;
        if (concl_a) ca++;
        if (concl_b) cb++;
        if (erro_a) ea++;
        if (erro_b) eb++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [6:0] d);
        iniciar_a = 1'b0;
        tick(1);
        duzias_in = d;
        iniciar_a = 1'b1;
        tick(1);
    endtask

    initial begin
        reset = 1'b0; iniciar_a = 1'b0; iniciar_b = 1'b0; duzias_in = 7'd0; cancelar = 1'b0;
        tick(2);
        iniciar_a = 1'b1; duzias_in = 7'd5; cancelar = 1'b1;
        tick(1);
        iniciar_a = 1'b0; cancelar = 1'b0;
        tick(1);
        iniciar_a = 1'b1;
        tick(1);
        check("rst_outs_a", int'({incr_a, ocup_a, concl_a, erro_a, dr_a, ur_a}), 0);
        check("rst_outs_b", int'({incr_b, ocup_b, concl_b, erro_b, dr_b, ur_b}), 0);
        sp = pa;
        reset = 1'b1;
        tick(5);
        check("rst_held_pulses", pa - sp, 0);
        check("rst_held_ocup", int'(ocup_a), 0);

        sp = pa; sc = ca;
        start_a(7'd1);
        check("d1_first_high", int'(incr_a), 1);
        check("d1_ur_load", int'(ur_a), 12);
        check("d1_dr_load", int'(dr_a), 1);
        check("d1_ocup", int'(ocup_a), 1);
        tick(1);
        check("d1_low", int'(incr_a), 0);
        check("d1_ur_11", int'(ur_a), 11);
        tick(1);
        check("d1_high2", int'(incr_a), 1);
        tick(21);
        check("d1_concl_early", int'(concl_a), 0);
        tick(1);
        check("d1_concl", int'(concl_a), 1);
        check("d1_ocup_fim", int'(ocup_a), 1);
        check("d1_dr_end", int'(dr_a), 0);
        check("d1_ur_end", int'(ur_a), 0);
        check("d1_pulses", pa - sp, 12);
        tick(1);
        check("d1_idle_ocup", int'(ocup_a), 0);
        check("d1_concl_count", ca - sc, 1);
        check("d1_dozens", (pa - sp) / 12, 1);

        sp = pb; sc = cb;
        duzias_in = 7'd10;
        iniciar_b = 1'b1;
        tick(1);
        check("d10_h0", int'(incr_b), 1);
        tick(1);
        check("d10_h1", int'(incr_b), 1);
        tick(1);
        check("d10_l0", int'(incr_b), 0);
        tick(2);
        check("d10_l2", int'(incr_b), 0);
        tick(1);
        check("d10_h_next", int'(incr_b), 1);
        tick(51);
        check("d10_dr_before", int'(dr_b), 10);
        check("d10_ur_before", int'(ur_b), 1);
        tick(1);
        check("d10_dr_step", int'(dr_b), 9);
        check("d10_ur_reload", int'(ur_b), 12);
        tick(542);
        check("d10_concl_early", int'(concl_b), 0);
        tick(1);
        check("d10_concl", int'(concl_b), 1);
        check("d10_dr_end", int'(dr_b), 0);
        check("d10_pulses", pb - sp, 120);
        tick(1);
        check("d10_idle", int'(ocup_b), 0);
        check("d10_concl_count", cb - sc, 1);
        check("d10_dozens", (pb - sp) / 12, 10);
        check("d10_a_quiet", int'(ocup_a), 0);

        sp = pa; se = ea;
        start_a(7'd0);
        check("inv0_erro", int'(erro_a), 1);
        check("inv0_ocup", int'(ocup_a), 0);
        tick(1);
        check("inv0_erro_drop", int'(erro_a), 0);
        start_a(7'd11);
        check("inv11_erro", int'(erro_a), 1);
        check("inv11_ocup", int'(ocup_a), 0);
        tick(1);
        check("inv11_erro_drop", int'(erro_a), 0);
        check("inv_pulses", pa - sp, 0);
        check("inv_erro_count", ea - se, 2);
        check("inv_dr_kept", int'(dr_a), 0);

        sp = pa; sc = ca;
        start_a(7'd3);
        tick(32);
        check("can_in_high", int'(incr_a), 1);
        cancelar = 1'b1;
        tick(1);
        cancelar = 1'b0;
        check("can_low_full", int'(incr_a), 0);
        tick(1);
        check("can_concl", int'(concl_a), 1);
        check("can_pulses", pa - sp, 17);
        check("can_dr", int'(dr_a), 2);
        check("can_ur", int'(ur_a), 7);
        tick(4);
        check("can_idle", int'(ocup_a), 0);
        check("can_concl_count", ca - sc, 1);
        check("can_pulses_after", pa - sp, 17);

        sp = pa; se = ea;
        start_a(7'd1);
        tick(5);
        iniciar_a = 1'b0;
        tick(1);
        duzias_in = 7'd5;
        iniciar_a = 1'b1;
        tick(1);
        tick(17);
        check("re_concl", int'(concl_a), 1);
        check("re_pulses", pa - sp, 12);
        check("re_dr", int'(dr_a), 0);
        check("re_no_erro", ea - se, 0);
        tick(1);

        start_a(7'd2);
        check("mid_in_high", int'(incr_a), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_incr", int'(incr_a), 0);
        check("mid_rst_counts", int'({dr_a, ur_a}), 0);
        check("mid_rst_ocup", int'(ocup_a), 0);
        tick(1);
        reset = 1'b1;
        tick(2);
        check("mid_rst_stays_idle", int'(ocup_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
